// File: rtl/ita_requantizer_pipe_pkg.sv
// rtl/ita_requantizer_pipe_pkg.sv - shared types and default widths for the requantizer pipeline
package ita_requantizer_pipe_pkg;

   localparam int DEF_N   = 16;
   localparam int DEF_WO  = 26;
   localparam int DEF_WI  = 8;
   localparam int DEF_EMS = 8;
   localparam int DEF_SHW = 5;
   localparam int DEF_CW  = 16;

   // Encoding 3 is reserved and behaves like floor.
   typedef enum logic [1:0] {
      RND_FLOOR     = 2'd0,
      RND_HALF_UP   = 2'd1,
      RND_HALF_EVEN = 2'd2
   } rnd_mode_e;

   typedef struct packed {
      logic [DEF_EMS-1:0] eps;
      logic [DEF_SHW-1:0] shift;
   } requant_lane_cfg_t;

endpackage

// File: rtl/ita_requantizer_pipe_if.sv
// rtl/ita_requantizer_pipe_if.sv - beat-in / result-out handshake bundle of the requantizer
interface ita_requantizer_pipe_if
   import ita_requantizer_pipe_pkg::*;
#(
   parameter int N   = DEF_N,
   parameter int WO  = DEF_WO,
   parameter int WI  = DEF_WI,
   parameter int EMS = DEF_EMS,
   parameter int SHW = DEF_SHW
) ();

   logic               in_valid;
   logic               in_ready;
   logic               is_signed;
   logic [1:0]         rnd_mode;
   logic [N*EMS-1:0]   eps_mult;
   logic [N*SHW-1:0]   right_shift;
   logic [N*WO-1:0]    result;
   logic [N*WI-1:0]    add;
   logic               out_valid;
   logic               out_ready;
   logic [N*WI-1:0]    requant_oup;
   logic [N-1:0]       sat;

   modport master (
      output in_valid, is_signed, rnd_mode, eps_mult, right_shift, result, add, out_ready,
      input  in_ready, out_valid, requant_oup, sat
   );

   modport slave (
      input  in_valid, is_signed, rnd_mode, eps_mult, right_shift, result, add, out_ready,
      output in_ready, out_valid, requant_oup, sat
   );

endinterface

// File: rtl/ita_requant_lane.sv
// rtl/ita_requant_lane.sv - combinational multiply / shift-round / residual-saturate datapath of one lane
module ita_requant_lane
   import ita_requantizer_pipe_pkg::*;
#(
   parameter int WO  = DEF_WO,
   parameter int WI  = DEF_WI,
   parameter int EMS = DEF_EMS,
   parameter int SHW = DEF_SHW,
   localparam int PW = EMS + WO + 1
) (
   input  logic                 is_signed,
   input  logic [EMS-1:0]       eps,
   input  logic [WO-1:0]        result,
   output logic signed [PW-1:0] prod,
   input  logic signed [PW-1:0] prod_q,
   input  logic [SHW-1:0]       shift,
   input  rnd_mode_e            rnd_mode,
   output logic signed [PW-1:0] quot,
   input  logic signed [PW-1:0] quot_q,
   input  logic [WI-1:0]        add,
   output logic [WI-1:0]        oup,
   output logic                 sat
);

   localparam int SMAX = EMS + WO;
   localparam int SW   = $clog2(PW);
   localparam logic signed [PW:0] SAT_HI = (PW+1)'((2 ** (WI - 1)) - 1);
   localparam logic signed [PW:0] SAT_LO = ~SAT_HI;

   logic signed [PW-1:0] x_ext;
   logic signed [PW-1:0] e_ext;
   logic [SW-1:0]        s_amt;
   logic [PW-1:0]        low_mask;
   logic [PW-1:0]        st_mask;
   logic                 half;
   logic                 sticky;
   logic                 inc;
   logic signed [PW-1:0] q_flr;
   logic signed [PW:0]   t;

   // S1: full-width product of the zero-extended multiplier and the (optionally signed) lane
   always_comb begin
      x_ext = {{(PW-WO){is_signed & result[WO-1]}}, result};
      e_ext = {{(PW-EMS){1'b0}}, eps};
      prod  = x_ext * e_ext;
   end

   // S2: clamp the shift, floor-shift, then add the rounding increment chosen by the mode
   always_comb begin
      s_amt    = (int'(shift) > SMAX) ? SW'(SMAX) : SW'(shift);
      low_mask = ({{(PW-1){1'b0}}, 1'b1} << s_amt) - {{(PW-1){1'b0}}, 1'b1};
      st_mask  = low_mask >> 1;
      half     = |(prod_q & (low_mask & ~st_mask));
      sticky   = |(prod_q & st_mask);
      q_flr    = prod_q >>> s_amt;
      case (rnd_mode)
         RND_HALF_UP:   inc = half;
         RND_HALF_EVEN: inc = half & (sticky | q_flr[0]);
         default:       inc = 1'b0;
      endcase
      quot = q_flr + $signed({{(PW-1){1'b0}}, inc});
   end

   // S3: add the signed residual one bit wider than the quotient and clip to the output range
   always_comb begin
      t   = $signed({quot_q[PW-1], quot_q}) + $signed({{(PW+1-WI){add[WI-1]}}, add});
      oup = t[WI-1:0];
      sat = 1'b0;
      if (t > SAT_HI) begin
         oup = SAT_HI[WI-1:0];
         sat = 1'b1;
      end else if (t < SAT_LO) begin
         oup = SAT_LO[WI-1:0];
         sat = 1'b1;
      end
   end

endmodule

// File: rtl/ita_requantizer_pipe.sv
// rtl/ita_requantizer_pipe.sv - three-stage elastic N-lane requantizer with sticky saturation counter
module ita_requantizer_pipe
   import ita_requantizer_pipe_pkg::*;
#(
   parameter int N   = DEF_N,
   parameter int WO  = DEF_WO,
   parameter int WI  = DEF_WI,
   parameter int EMS = DEF_EMS,
   parameter int SHW = DEF_SHW,
   parameter int CW  = DEF_CW
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   ita_requantizer_pipe_if.slave bus,
   output logic [CW-1:0]         sat_cnt,
   input  logic                  sat_clr
);

   localparam int PW = EMS + WO + 1;

   logic              init_done;
   logic              v1, v2, v3;
   logic              en1, en2, en3;
   logic              accept;
   logic              out_fire;
   logic [N*PW-1:0]   p1, q2;
   logic [N*SHW-1:0]  sh1;
   logic [1:0]        mode1;
   logic [N*WI-1:0]   add1, add2;
   logic [N*WI-1:0]   oup3;
   logic [N-1:0]      sat3;
   logic [N*PW-1:0]   prod_c, quot_c;
   logic [N*WI-1:0]   oup_c;
   logic [N-1:0]      sat_c;

   // A stage may load when it is empty or its contents move on this cycle
   assign en3      = !v3 | bus.out_ready;
   assign en2      = !v2 | en3;
   assign en1      = !v1 | en2;
   assign accept   = bus.in_valid & bus.in_ready;
   assign out_fire = v3 & bus.out_ready;

   assign bus.in_ready    = init_done & en1;
   assign bus.out_valid   = v3;
   assign bus.requant_oup = oup3;
   assign bus.sat         = sat3;

   for (genvar i = 0; i < N; i++) begin : g_lane
      ita_requant_lane #(
         .WO  (WO),
         .WI  (WI),
         .EMS (EMS),
         .SHW (SHW)
      ) u_lane (
         .is_signed (bus.is_signed),
         .eps       (bus.eps_mult[i*EMS +: EMS]),
         .result    (bus.result[i*WO +: WO]),
         .prod      (prod_c[i*PW +: PW]),
         .prod_q    (p1[i*PW +: PW]),
         .shift     (sh1[i*SHW +: SHW]),
         .rnd_mode  (rnd_mode_e'(mode1)),
         .quot      (quot_c[i*PW +: PW]),
         .quot_q    (q2[i*PW +: PW]),
         .add       (add2[i*WI +: WI]),
         .oup       (oup_c[i*WI +: WI]),
         .sat       (sat_c[i])
      );
   end

   // Hold off ready until the first clock after reset release
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) init_done <= 1'b0;
      else         init_done <= 1'b1;
   end

   // Stage 1: capture product plus the config and residual that travel with the beat
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         v1    <= 1'b0;
         p1    <= '0;
         sh1   <= '0;
         mode1 <= '0;
         add1  <= '0;
      end else if (en1) begin
         v1 <= accept;
         if (accept) begin
            p1    <= prod_c;
            sh1   <= bus.right_shift;
            mode1 <= bus.rnd_mode;
            add1  <= bus.add;
         end
      end
   end

   // Stage 2: capture the rounded quotient and forward the residual
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         v2   <= 1'b0;
         q2   <= '0;
         add2 <= '0;
      end else if (en2) begin
         v2 <= v1;
         if (v1) begin
            q2   <= quot_c;
            add2 <= add1;
         end
      end
   end

   // Stage 3: output register, held while downstream stalls
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         v3   <= 1'b0;
         oup3 <= '0;
         sat3 <= '0;
      end else if (en3) begin
         v3 <= v2;
         if (v2) begin
            oup3 <= oup_c;
            sat3 <= sat_c;
         end
      end
   end

   // Count delivered beats with any clipped lane; clear has priority and the count sticks at max
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sat_cnt <= '0;
      end else if (sat_clr) begin
         sat_cnt <= '0;
      end else if (out_fire && (|sat3) && (sat_cnt != {CW{1'b1}})) begin
         sat_cnt <= sat_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_ita_requantizer_pipe.sv
// tb/tb_ita_requantizer_pipe.sv - directed self-checking bench for the requantizer pipeline
module tb_ita_requantizer_pipe;
   import ita_requantizer_pipe_pkg::*;

   localparam int N = 16, WO = 26, WI = 8, EMS = 8, SHW = 5, CW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          sat_clr;
   logic [CW-1:0] sat_cnt;
   int            n_checks = 0;
   int            n_fail   = 0;

   always #5 clk = ~clk;

   ita_requantizer_pipe_if #(.N(N), .WO(WO), .WI(WI), .EMS(EMS), .SHW(SHW)) bus ();

   ita_requantizer_pipe #(.N(N), .WO(WO), .WI(WI), .EMS(EMS), .SHW(SHW), .CW(CW)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .bus     (bus),
      .sat_cnt (sat_cnt),
      .sat_clr (sat_clr)
   );

   function automatic logic [N*EMS-1:0] rep_e(input logic [EMS-1:0] v); return {N{v}}; endfunction
   function automatic logic [N*SHW-1:0] rep_s(input logic [SHW-1:0] v); return {N{v}}; endfunction
   function automatic logic [N*WO-1:0]  rep_r(input logic [WO-1:0] v);  return {N{v}}; endfunction
   function automatic logic [N*WI-1:0]  rep_o(input logic [WI-1:0] v);  return {N{v}}; endfunction

   function automatic logic [N*WI-1:0] bp_vec(input int k);
      logic [N*WI-1:0] v;
      for (int i = 0; i < N; i++) v[i*WI +: WI] = WI'(k * 10 + i);
      return v;
   endfunction

   task automatic send_beat(input logic sgn, input logic [1:0] mode, input logic [N*EMS-1:0] eps,
                            input logic [N*SHW-1:0] sh, input logic [N*WO-1:0] res,
                            input logic [N*WI-1:0] add, output logic [N*WI-1:0] oup,
                            output logic [N-1:0] sat, output int lat);
      int wait_c;
      @(negedge clk);
      bus.is_signed = sgn; bus.rnd_mode = mode; bus.eps_mult = eps;
      bus.right_shift = sh; bus.result = res; bus.add = add;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      #1;
      wait_c = 0;
      while (!bus.in_ready && wait_c < 20) begin
         @(negedge clk); #1; wait_c++;
      end
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         lat++;
      end while (!bus.out_valid && lat < 20);
      oup = bus.requant_oup;
      sat = bus.sat;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
      n_checks++; if (bus.requant_oup !== '0) begin n_fail++; $display("FAIL reset_oup: got %h expected 0", bus.requant_oup); end
      n_checks++; if (bus.sat !== '0) begin n_fail++; $display("FAIL reset_sat: got %h expected 0", bus.sat); end
      n_checks++; if (sat_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", sat_cnt); end
      rst_n = 1'b1;
      #1;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_early: got %b expected 0", bus.in_ready); end
      @(negedge clk);
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.in_ready); end
   endtask

   task automatic test_basic();
      requant_lane_cfg_t cfg [N];
      logic [N*EMS-1:0] eps; logic [N*SHW-1:0] sh; logic [N*WO-1:0] res;
      logic [N*WI-1:0] add, exp_o, oup; logic [N-1:0] sat; int lat;
      cfg[0] = '{eps: 8'd3, shift: 5'd4};
      cfg[1] = '{eps: 8'd1, shift: 5'd4};
      res[0*WO +: WO] = WO'(500); add[0*WI +: WI] = WI'(-10); exp_o[0*WI +: WI] = WI'(84);
      res[1*WO +: WO] = WO'(40);  add[1*WI +: WI] = WI'(0);   exp_o[1*WI +: WI] = WI'(3);
      for (int i = 2; i < N; i++) begin
         cfg[i] = '{eps: 8'd2, shift: 5'd1};
         res[i*WO +: WO] = WO'(i); add[i*WI +: WI] = WI'(i); exp_o[i*WI +: WI] = WI'(2 * i);
      end
      for (int i = 0; i < N; i++) begin
         eps[i*EMS +: EMS] = cfg[i].eps;
         sh[i*SHW +: SHW]  = cfg[i].shift;
      end
      send_beat(1'b1, 2'd1, eps, sh, res, add, oup, sat, lat);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", lat); end
      n_checks++; if (oup !== exp_o) begin n_fail++; $display("FAIL basic_oup: got %h expected %h", oup, exp_o); end
      n_checks++; if (sat !== '0) begin n_fail++; $display("FAIL basic_sat: got %h expected 0", sat); end
      @(negedge clk);
      n_checks++; if (sat_cnt !== '0) begin n_fail++; $display("FAIL basic_cnt: got %0d expected 0", sat_cnt); end
   endtask

   task automatic test_rounding();
      int rres [9] = '{40, 40, 40, 56, -40, -40, -40, 41, -24};
      int rmode[9] = '{0, 1, 2, 2, 0, 1, 2, 2, 2};
      int rexp [9] = '{2, 3, 2, 4, -3, -2, -2, 3, -2};
      logic [WO-1:0] r1; logic [WI-1:0] e1;
      logic [N*WI-1:0] oup; logic [N-1:0] sat; int lat;
      for (int k = 0; k < 9; k++) begin
         r1 = WO'(rres[k]); e1 = WI'(rexp[k]);
         send_beat(1'b1, 2'(rmode[k]), rep_e(8'd1), rep_s(5'd4), rep_r(r1), '0, oup, sat, lat);
         n_checks++;
         if (oup !== rep_o(e1) || sat !== '0 || lat !== 3)
            begin n_fail++; $display("FAIL round_%0d: got %h sat %h lat %0d expected lane %0d", k, oup, sat, lat, rexp[k]); end
      end
   endtask

   task automatic test_saturation();
      int sres[5] = '{1000, -1000, 100, -100, 100};
      int seps[5] = '{3, 3, 1, 1, 1};
      int ssh [5] = '{4, 4, 0, 0, 0};
      int sadd[5] = '{0, 0, 27, -28, 28};
      int sexp[5] = '{127, -128, 127, -128, 127};
      int ssat[5] = '{1, 1, 0, 0, 1};
      int scnt[5] = '{1, 2, 2, 2, 3};
      logic [WO-1:0] r1; logic [WI-1:0] e1, a1;
      logic [N*WI-1:0] oup; logic [N-1:0] sat; int lat;
      @(negedge clk); sat_clr = 1'b1;
      @(negedge clk); sat_clr = 1'b0;
      for (int k = 0; k < 5; k++) begin
         r1 = WO'(sres[k]); e1 = WI'(sexp[k]); a1 = WI'(sadd[k]);
         send_beat(1'b1, 2'd1, rep_e(EMS'(seps[k])), rep_s(SHW'(ssh[k])), rep_r(r1), rep_o(a1), oup, sat, lat);
         n_checks++; if (oup !== rep_o(e1)) begin n_fail++; $display("FAIL sat_oup_%0d: got %h expected lane %0d", k, oup, sexp[k]); end
         n_checks++; if (sat !== {N{ssat[k][0]}}) begin n_fail++; $display("FAIL sat_flag_%0d: got %h expected %0d per lane", k, sat, ssat[k]); end
         @(negedge clk);
         n_checks++; if (sat_cnt !== CW'(scnt[k])) begin n_fail++; $display("FAIL sat_cnt_%0d: got %0d expected %0d", k, sat_cnt, scnt[k]); end
      end
   endtask

   task automatic test_unsigned();
      logic [N*WI-1:0] oup; logic [N-1:0] sat; int lat;
      send_beat(1'b0, 2'd1, rep_e(8'd1), rep_s(5'(WO - 7)), rep_r({WO{1'b1}}), '0, oup, sat, lat);
      n_checks++; if (oup !== rep_o(8'd127) || sat !== '1) begin n_fail++; $display("FAIL unsigned_mode: got %h sat %h expected lane 127 sat 1", oup, sat); end
      send_beat(1'b1, 2'd1, rep_e(8'd1), rep_s(5'(WO - 7)), rep_r({WO{1'b1}}), '0, oup, sat, lat);
      n_checks++; if (oup !== '0 || sat !== '0) begin n_fail++; $display("FAIL signed_allones: got %h sat %h expected 0 sat 0", oup, sat); end
   endtask

   task automatic test_back_to_back();
      int sent = 0, rcv = 0, extra = 0;
      logic prev_stall = 1'b0, saw_full = 1'b0, stall;
      logic [N*WI-1:0] held = '0;
      logic [N*WO-1:0] res;
      bus.is_signed = 1'b1; bus.rnd_mode = 2'd0; bus.eps_mult = rep_e(8'd1);
      bus.right_shift = rep_s(5'd0); bus.add = '0;
      for (int c = 0; c < 300 && rcv < 10; c++) begin
         @(negedge clk);
         if (prev_stall) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.requant_oup !== held)
               begin n_fail++; $display("FAIL bp_hold_c%0d: got v=%b %h expected v=1 %h", c, bus.out_valid, bus.requant_oup, held); end
         end
         stall = ((c >= 4 && c < 9) || (c >= 15 && c < 20)) ? 1'b1 : 1'($urandom_range(0, 1));
         bus.out_ready = !stall;
         if (sent < 10) begin
            for (int i = 0; i < N; i++) res[i*WO +: WO] = WO'(sent * 10 + i);
            bus.result = res; bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         #1;
         if (!bus.in_ready) begin
            saw_full = 1'b1; n_checks++;
            if (!(bus.out_valid && !bus.out_ready))
               begin n_fail++; $display("FAIL bp_ready_low_c%0d: got ready 0 with v=%b r=%b expected stalled output", c, bus.out_valid, bus.out_ready); end
         end
         if (bus.in_valid && bus.in_ready) sent++;
         if (bus.out_valid && bus.out_ready) begin
            n_checks++;
            if (bus.requant_oup !== bp_vec(rcv)) begin n_fail++; $display("FAIL bp_beat_%0d: got %h expected %h", rcv, bus.requant_oup, bp_vec(rcv)); end
            rcv++;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         held = bus.requant_oup;
      end
      n_checks++; if (rcv !== 10) begin n_fail++; $display("FAIL bp_count: got %0d expected 10", rcv); end
      n_checks++; if (saw_full !== 1'b1) begin n_fail++; $display("FAIL bp_full: got %b expected 1", saw_full); end
      @(negedge clk); bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin @(negedge clk); if (bus.out_valid) extra++; end
      n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL bp_dup: got %0d extra beats expected 0", extra); end
   endtask

   task automatic test_counter();
      int tgt = (2 ** CW) + 3, acc = 0, nout = 0;
      logic [N*WI-1:0] oup; logic [N-1:0] sat; int lat;
      @(negedge clk); sat_clr = 1'b1;
      @(negedge clk); sat_clr = 1'b0;
      n_checks++; if (sat_cnt !== '0) begin n_fail++; $display("FAIL cnt_clear: got %0d expected 0", sat_cnt); end
      bus.is_signed = 1'b1; bus.rnd_mode = 2'd1; bus.eps_mult = rep_e(8'd3);
      bus.right_shift = rep_s(5'd4); bus.result = rep_r(WO'(1000)); bus.add = '0; bus.out_ready = 1'b1;
      for (int c = 0; c < tgt + 50 && nout < tgt; c++) begin
         @(negedge clk);
         bus.in_valid = (acc < tgt);
         #1;
         if (bus.in_valid && bus.in_ready) acc++;
         if (bus.out_valid && bus.out_ready) nout++;
      end
      @(negedge clk); bus.in_valid = 1'b0;
      n_checks++; if (nout !== tgt) begin n_fail++; $display("FAIL cnt_beats: got %0d expected %0d", nout, tgt); end
      n_checks++; if (sat_cnt !== {CW{1'b1}}) begin n_fail++; $display("FAIL cnt_saturate: got %0d expected %0d", sat_cnt, 2 ** CW - 1); end
      @(negedge clk); sat_clr = 1'b1;
      @(negedge clk); sat_clr = 1'b0;
      send_beat(1'b1, 2'd1, rep_e(8'd3), rep_s(5'd4), rep_r(WO'(1000)), '0, oup, sat, lat);
      @(negedge clk);
      n_checks++; if (sat_cnt !== CW'(1)) begin n_fail++; $display("FAIL cnt_one: got %0d expected 1", sat_cnt); end
      send_beat(1'b1, 2'd1, rep_e(8'd3), rep_s(5'd4), rep_r(WO'(1000)), '0, oup, sat, lat);
      sat_clr = 1'b1;
      @(negedge clk); sat_clr = 1'b0;
      n_checks++; if (sat_cnt !== '0) begin n_fail++; $display("FAIL cnt_clr_wins: got %0d expected 0", sat_cnt); end
   endtask

   task automatic test_async_reset();
      int stale = 0;
      bus.is_signed = 1'b1; bus.rnd_mode = 2'd1; bus.eps_mult = rep_e(8'd3);
      bus.right_shift = rep_s(5'd4); bus.result = rep_r(WO'(500)); bus.add = rep_o(WI'(-10));
      for (int c = 0; c < 6; c++) begin
         @(negedge clk); bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      end
      @(negedge clk);
      n_checks++; if (bus.out_valid !== 1'b1 || bus.requant_oup !== rep_o(8'd84))
         begin n_fail++; $display("FAIL ar_pre: got v=%b %h expected v=1 lane 84", bus.out_valid, bus.requant_oup); end
      #2 rst_n = 1'b0; bus.in_valid = 1'b0;
      #1;
      n_checks++; if (bus.out_valid !== 1'b0 || bus.requant_oup !== '0 || bus.sat !== '0)
         begin n_fail++; $display("FAIL ar_immediate: got v=%b %h sat %h expected all 0", bus.out_valid, bus.requant_oup, bus.sat); end
      @(negedge clk); rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin @(negedge clk); if (bus.out_valid) stale++; end
      n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL ar_stale: got %0d beats expected 0", stale); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready: got %b expected 1", bus.in_ready); end
   endtask

   initial begin
      rst_n = 1'b0; sat_clr = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.is_signed = 1'b1; bus.rnd_mode = 2'd0;
      bus.eps_mult = '0; bus.right_shift = '0; bus.result = '0; bus.add = '0;
      test_reset();
      test_basic();
      test_rounding();
      test_saturation();
      test_unsigned();
      test_back_to_back();
      test_counter();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
